// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types, widths and helpers for the instruction memory loader
package imem_loader_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int HDR_W  = 16;

   // Frame parser states: two header bytes, payload, checksum, then a terminal state
   typedef enum logic [2:0] {
      S_HDR_HI = 3'd0,
      S_HDR_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CHK    = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   // Byte address of a word slot; wraps modulo 2^32 by construction
   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [HDR_W-1:0]  idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction memory write port
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic              byte_valid;
   logic [BYTE_W-1:0] byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   // Loader side: consumes bytes, drives the memory write port
   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   // Source / memory side: presents bytes, observes writes
   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs four bytes MSB-first into a registered word
module word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              shift_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [1:0]        cnt_o,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o
);

   logic [23:0]       buf_q, buf_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;

   // Shift bytes in; the 4th byte completes the word and raises a one-cycle strobe
   always_comb begin
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clr_i) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (shift_i) begin
         buf_d = {buf_q[15:0], byte_i};
         cnt_d = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            word_d  = {buf_q, byte_i};
            valid_d = 1'b1;
         end
      end
   end

   // State registers; reset drops any partially assembled word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign cnt_o        = cnt_q;
   assign word_o       = word_q;
   assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory writer with CPU release
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int                MAX_WORDS = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   imem_loader_if.slave bus,
   input  logic         clear,
   output logic         done,
   output logic         error,
   output logic         cpu_run
);

   localparam logic [WORD_W-1:0] MAX_W = 32'(MAX_WORDS);

   state_e            state_q;
   logic [HDR_W-1:0]  n_q;
   logic [HDR_W-1:0]  word_cnt_q;
   logic [BYTE_W-1:0] chk_q;
   logic [WORD_W-1:0] addr_q;
   logic              ready_q;
   logic              done_q;
   logic              error_q;

   logic              accept;
   logic              terminal;
   logic              restart;
   logic [HDR_W-1:0]  n_full;
   logic              pk_shift;
   logic              pk_clr;
   logic [1:0]        pk_cnt;
   logic [WORD_W-1:0] pk_word;
   logic              pk_valid;

   assign accept   = bus.byte_valid && ready_q;
   assign terminal = (state_q == S_DONE) || (state_q == S_ERR);
   assign restart  = clear && terminal;
   assign n_full   = {n_q[HDR_W-1:BYTE_W], bus.byte_data};
   assign pk_shift = accept && (state_q == S_DATA);
   assign pk_clr   = restart || (accept && (state_q == S_HDR_LO));

   word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (pk_clr),
      .shift_i      (pk_shift),
      .byte_i       (bus.byte_data),
      .cnt_o        (pk_cnt),
      .word_o       (pk_word),
      .word_valid_o (pk_valid)
   );

   // Frame FSM with checksum, word count, write address and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_HDR_HI;
         n_q        <= '0;
         word_cnt_q <= '0;
         chk_q      <= '0;
         addr_q     <= '0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         // Ready comes up the cycle after reset and stays up until a terminal state
         if (!terminal) begin
            ready_q <= 1'b1;
         end
         case (state_q)
            S_HDR_HI: begin
               if (accept) begin
                  n_q[HDR_W-1:BYTE_W] <= bus.byte_data;
                  state_q             <= S_HDR_LO;
               end
            end
            S_HDR_LO: begin
               if (accept) begin
                  n_q        <= n_full;
                  word_cnt_q <= '0;
                  chk_q      <= '0;
                  if ({16'd0, n_full} > MAX_W) begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                     ready_q <= 1'b0;
                  end else if (n_full == '0) begin
                     state_q <= S_CHK;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  chk_q <= chk_q ^ bus.byte_data;
                  if (pk_cnt == 2'd3) begin
                     addr_q     <= word_addr(BASE_ADDR, word_cnt_q);
                     word_cnt_q <= word_cnt_q + 16'd1;
                     if (word_cnt_q == n_q - 16'd1) begin
                        state_q <= S_CHK;
                     end
                  end
               end
            end
            S_CHK: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  if (bus.byte_data == chk_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (clear) begin
                  state_q    <= S_HDR_HI;
                  n_q        <= '0;
                  word_cnt_q <= '0;
                  chk_q      <= '0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  ready_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= S_HDR_HI;
            end
         endcase
      end
   end

   assign bus.byte_ready = ready_q;
   assign bus.mem_we     = pk_valid;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = pk_word;
   assign done           = done_q;
   assign error          = error_q;
   assign cpu_run        = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader at two base addresses
module tb_imem_loader;

   typedef struct {
      string       name;
      int          nbytes;
      logic [87:0] b;
      bit          gap;
      int          nwr;
      logic [31:0] d0;
      logic [31:0] d1;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;
   logic done0, error0, run0;
   logic done1, error1, run1;

   imem_loader_if bus0 ();
   imem_loader_if bus1 ();

   imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .clear(clear),
      .done(done0), .error(error0), .cpu_run(run0)
   );

   imem_loader #(.BASE_ADDR(32'h0000_0004), .MAX_WORDS(256)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .clear(clear),
      .done(done1), .error(error1), .cpu_run(run1)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   logic [63:0] wq0[$];
   logic [63:0] wq1[$];

   // Record every write strobe of both instances
   always @(negedge clk) begin
      if (bus0.mem_we) wq0.push_back({bus0.mem_addr, bus0.mem_wdata});
      if (bus1.mem_we) wq1.push_back({bus1.mem_addr, bus1.mem_wdata});
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      bus0.byte_valid = v;
      bus0.byte_data  = d;
      bus1.byte_valid = v;
      bus1.byte_data  = d;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int guard;
      if (gap) begin
         for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
            drive(1'b0, 8'h00);
            @(posedge clk); #1;
         end
      end
      drive(1'b1, b);
      guard = 0;
      @(negedge clk);
      while (!bus0.byte_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!bus0.byte_ready) begin
         check("ready_timeout", 32'(bus0.byte_ready), 32'd1);
         drive(1'b0, 8'h00);
         return;
      end
      @(posedge clk); #1;
      drive(1'b0, 8'h00);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int s0, s1;
      wq0.delete();
      wq1.delete();
      for (int i = 0; i < v.nbytes; i++) send_byte(v.b[87-8*i -: 8], v.gap);
      check({v.name, "_done"},  32'(done0),  32'(v.exp_done));
      check({v.name, "_error"}, 32'(error0), 32'(v.exp_err));
      check({v.name, "_run"},   32'(run0),   32'(v.exp_done));
      check({v.name, "_done1"}, 32'(done1),  32'(v.exp_done));
      check({v.name, "_ready"}, 32'(bus0.byte_ready), 32'd0);
      check({v.name, "_nwr0"},  32'(wq0.size()), 32'(v.nwr));
      check({v.name, "_nwr1"},  32'(wq1.size()), 32'(v.nwr));
      if (v.nwr >= 1 && wq0.size() >= 1 && wq1.size() >= 1) begin
         check({v.name, "_w0_addr"},  wq0[0][63:32], 32'h0);
         check({v.name, "_w0_data"},  wq0[0][31:0],  v.d0);
         check({v.name, "_w0_addr1"}, wq1[0][63:32], 32'h4);
         check({v.name, "_w0_data1"}, wq1[0][31:0],  v.d0);
      end
      if (v.nwr >= 2 && wq0.size() >= 2 && wq1.size() >= 2) begin
         check({v.name, "_w1_addr"},  wq0[1][63:32], 32'h4);
         check({v.name, "_w1_data"},  wq0[1][31:0],  v.d1);
         check({v.name, "_w1_addr1"}, wq1[1][63:32], 32'h8);
         check({v.name, "_w1_data1"}, wq1[1][31:0],  v.d1);
      end
      // Bytes offered in a terminal state are refused and change nothing
      s0 = wq0.size();
      s1 = wq1.size();
      drive(1'b1, 8'h55);
      repeat (3) @(posedge clk);
      #1;
      drive(1'b0, 8'h00);
      check({v.name, "_hold_ready"}, 32'(bus0.byte_ready), 32'd0);
      check({v.name, "_hold_state"}, {30'd0, done0, error0}, {30'd0, v.exp_done, v.exp_err});
      check({v.name, "_hold_nwr"}, 32'(wq0.size() + wq1.size()), 32'(s0 + s1));
      pulse_clear();
      check({v.name, "_clr_flags"}, {29'd0, done0, error0, run0}, 32'd0);
      check({v.name, "_clr_ready"}, 32'(bus0.byte_ready), 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      logic [7:0] q[$];
      logic [7:0] cx;
      logic [31:0] w;
      int errs;

      vecs[0] = '{"nominal",   11, 88'h0002_2008_0005_8C09_0004_AC, 1'b0, 2, 32'h20080005, 32'h8C090004, 1'b1, 1'b0};
      vecs[1] = '{"bad_chk",   11, 88'h0002_2008_0005_8C09_0004_AD, 1'b0, 2, 32'h20080005, 32'h8C090004, 1'b0, 1'b1};
      vecs[2] = '{"empty",      3, {24'h000000, 64'h0},              1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
      vecs[3] = '{"empty_bad",  3, {24'h000001, 64'h0},              1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[4] = '{"oversize",   2, {16'h012C, 72'h0},                1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[5] = '{"gapped",    11, 88'h0002_2008_0005_8C09_0004_AC, 1'b1, 2, 32'h20080005, 32'h8C090004, 1'b1, 1'b0};
      vecs[6] = '{"single",     7, {56'h0001_DEAD_BEEF_22, 32'h0},   1'b0, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
      vecs[7] = '{"reload",    11, 88'h0002_2008_0005_8C09_0004_AC, 1'b0, 2, 32'h20080005, 32'h8C090004, 1'b1, 1'b0};

      rst_n = 1'b0;
      clear = 1'b0;
      drive(1'b0, 8'h00);
      repeat (3) @(negedge clk);
      check("rst_flags", {29'd0, done0, error0, run0}, 32'd0);
      check("rst_we_ready", {30'd0, bus0.mem_we, bus0.byte_ready}, 32'd0);
      check("rst_addr_data", bus0.mem_addr | bus0.mem_wdata, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Write latency, then reset in the middle of the second word
      wq0.delete();
      wq1.delete();
      q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
      for (int i = 0; i < 8; i++) begin
         send_byte(q[i], 1'b0);
         if (i == 4) check("lat_we_before", 32'(bus0.mem_we), 32'd0);
         if (i == 5) begin
            check("lat_we",    32'(bus0.mem_we), 32'd1);
            check("lat_addr1", bus1.mem_addr,    32'h4);
            check("lat_data",  bus0.mem_wdata,   32'h20080005);
         end
         if (i == 6) check("lat_we_after", 32'(bus0.mem_we), 32'd0);
      end
      rst_n = 1'b0;
      #1;
      check("async_rst_addr1", bus1.mem_addr,  32'h0);
      check("async_rst_data1", bus1.mem_wdata, 32'h0);
      check("async_rst_ready", 32'(bus1.byte_ready), 32'd0);
      check("async_rst_flags", {29'd0, done1, error1, run1}, 32'd0);
      check("partial_writes", 32'(wq0.size()), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0]);

      // Clear outside DONE/ERR is ignored
      wq0.delete();
      wq1.delete();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      pulse_clear();
      q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      foreach (q[i]) send_byte(q[i], 1'b0);
      check("midclr_done", 32'(done0), 32'd1);
      check("midclr_nwr", 32'(wq0.size()), 32'd1);
      if (wq0.size() == 1) check("midclr_data", wq0[0][31:0], 32'hDEADBEEF);
      pulse_clear();

      // Largest legal frame: N = MAX_WORDS
      wq0.delete();
      wq1.delete();
      q = '{8'h01, 8'h00};
      cx = 8'h00;
      for (int i = 0; i < 256; i++) begin
         w = {8'(i), ~8'(i), 8'h5A, 8'(i)};
         for (int k = 3; k >= 0; k--) begin
            q.push_back(w[8*k +: 8]);
            cx = cx ^ w[8*k +: 8];
         end
      end
      q.push_back(cx);
      foreach (q[i]) send_byte(q[i], 1'b0);
      check("max_done", 32'(done0 & done1), 32'd1);
      check("max_nwr", 32'(wq0.size()), 32'd256);
      errs = 0;
      if (wq0.size() == 256 && wq1.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'h5A, 8'(i)};
            if (wq0[i] !== {32'(4 * i), w}) errs++;
            if (wq1[i] !== {32'(4 * i + 4), w}) errs++;
         end
         check("max_last_addr1", wq1[255][63:32], 32'h400);
      end else begin
         errs = 1;
      end
      check("max_data_errs", 32'(errs), 32'd0);
      pulse_clear();

      // One past capacity is rejected right after the header
      wq0.delete();
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check("over_257_error", 32'(error0), 32'd1);
      check("over_257_ready", 32'(bus0.byte_ready), 32'd0);
      check("over_257_nwr", 32'(wq0.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
